// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared state enum, default sizes and clog2 helper for the SAD minimum search
package sad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sad_state_e;

  localparam int DEF_SAD_W    = 8;
  localparam int DEF_COLS     = 64;
  localparam int DEF_NUM_CAND = 4096;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sad_min_cell.sv
// rtl/sad_min_cell.sv - combinational compare/update decision for one SAD candidate
module sad_min_cell
  import sad_pkg::*;
#(
  parameter int SAD_W = DEF_SAD_W
) (
  input  logic [SAD_W-1:0] cand_i,
  input  logic [SAD_W-1:0] cur_min_i,
  input  logic             first_i,
  input  logic             tie_last_i,
  output logic             replace_o,
  output logic             equal_o
);

  logic is_less;
  logic is_equal;

  assign is_less  = cand_i < cur_min_i;
  assign is_equal = cand_i == cur_min_i;

  // The first candidate always wins so an all-ones first value still lands in the working minimum.
  assign replace_o = first_i | is_less | (tie_last_i & is_equal);
  // Equality against the initial all-ones working minimum is not a real tie.
  assign equal_o   = is_equal & ~first_i;

endmodule

// File: rtl/sad_min_search.sv
// rtl/sad_min_search.sv - streaming minimum-SAD search with row/column location and tie count
module sad_min_search
  import sad_pkg::*;
#(
  parameter  int SAD_W    = DEF_SAD_W,
  parameter  int COLS     = DEF_COLS,
  parameter  int NUM_CAND = DEF_NUM_CAND,
  parameter  bit TIE_LAST = 1'b0,
  localparam int IDX_W    = clog2(NUM_CAND),
  localparam int Y_W      = clog2(COLS),
  localparam int X_W      = (clog2(NUM_CAND / COLS) < 1) ? 1 : clog2(NUM_CAND / COLS),
  localparam int TIE_W    = clog2(NUM_CAND) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [SAD_W-1:0] in_sad_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SAD_W-1:0] sad_o,
  output logic [X_W-1:0]   x_o,
  output logic [Y_W-1:0]   y_o,
  output logic [TIE_W-1:0] tie_cnt_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);
  localparam logic [TIE_W-1:0] TIE_MAX  = TIE_W'(NUM_CAND);

  sad_state_e        state_q, state_d;
  logic [SAD_W-1:0]  min_q, min_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  min_idx_q, min_idx_d;
  logic [TIE_W-1:0]  tie_q, tie_d;
  logic [SAD_W-1:0]  sad_out_q;
  logic [IDX_W-1:0]  idx_out_q;
  logic [TIE_W-1:0]  tie_out_q;

  logic accept;
  logic last_accept;
  logic replace;
  logic equal;

  sad_min_cell #(
    .SAD_W (SAD_W)
  ) u_cell (
    .cand_i     (in_sad_i),
    .cur_min_i  (min_q),
    .first_i    (idx_q == '0),
    .tie_last_i (TIE_LAST),
    .replace_o  (replace),
    .equal_o    (equal)
  );

  // Start always wins over a same-cycle candidate, so the first accept is the cycle after Start.
  assign accept      = (state_q == ST_SCAN) && in_valid_i && !start_i;
  assign last_accept = accept && (idx_q == LAST_IDX);

  // Next-state and working-register update; Start from any state re-initialises the scan.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    idx_d     = idx_q;
    min_idx_d = min_idx_q;
    tie_d     = tie_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (accept) begin
          if (replace) begin
            min_d     = in_sad_i;
            min_idx_d = idx_q;
          end
          if (equal) begin
            if (tie_q != TIE_MAX) tie_d = tie_q + 1'b1;
          end else if (replace) begin
            tie_d = TIE_W'(1);
          end
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = start_i ? ST_SCAN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_i) begin
      min_d     = '1;
      idx_d     = '0;
      min_idx_d = '0;
      tie_d     = '0;
    end
  end

  // State and working registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      min_q     <= '0;
      idx_q     <= '0;
      min_idx_q <= '0;
      tie_q     <= '0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      idx_q     <= idx_d;
      min_idx_q <= min_idx_d;
      tie_q     <= tie_d;
    end
  end

  // Result registers capture the final working values on the last accept, so they are valid with Done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sad_out_q <= '0;
      idx_out_q <= '0;
      tie_out_q <= '0;
    end else if (last_accept) begin
      sad_out_q <= min_d;
      idx_out_q <= min_idx_d;
      tie_out_q <= tie_d;
    end
  end

  assign busy_o    = (state_q == ST_SCAN);
  assign done_o    = (state_q == ST_DONE);
  assign sad_o     = sad_out_q;
  assign tie_cnt_o = tie_out_q;
  assign y_o       = idx_out_q[Y_W-1:0];

  // Row is the upper index bits; a single-row window has no row bits to slice.
  generate
    if (IDX_W > Y_W) begin : g_row
      assign x_o = X_W'(idx_out_q[IDX_W-1:Y_W]);
    end else begin : g_no_row
      assign x_o = '0;
    end
  endgenerate

endmodule

// File: tb/tb_sad_min_search.sv
// tb/tb_sad_min_search.sv - directed self-checking bench for sad_min_search (COLS=4, NUM_CAND=16)
module tb_sad_min_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_sad;

  logic       busy0, done0, busy1, done1;
  logic [7:0] sad0, sad1;
  logic [1:0] x0, y0, x1, y1;
  logic [4:0] tie0, tie1;

  int checks = 0;
  int errors = 0;
  int dn0 = 0;
  int dn1 = 0;
  int dn0_ref;
  int dn1_ref;

  always #5 clk = ~clk;

  sad_min_search #(.SAD_W(8), .COLS(4), .NUM_CAND(16), .TIE_LAST(1'b0)) u_dut_first (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid), .in_sad_i(in_sad),
    .busy_o(busy0), .done_o(done0), .sad_o(sad0), .x_o(x0), .y_o(y0), .tie_cnt_o(tie0)
  );

  sad_min_search #(.SAD_W(8), .COLS(4), .NUM_CAND(16), .TIE_LAST(1'b1)) u_dut_last (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid), .in_sad_i(in_sad),
    .busy_o(busy1), .done_o(done1), .sad_o(sad1), .x_o(x1), .y_o(y1), .tie_cnt_o(tie1)
  );

  always @(negedge clk) begin
    if (done0) dn0 <= dn0 + 1;
    if (done1) dn1 <= dn1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int vals[16], input int from, input int to, input int gap);
    for (int i = from; i <= to; i++) begin
      in_valid = 1'b1;
      in_sad   = 8'(vals[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < to) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  int v38[16] = '{9, 7, 5, 8, 3, 6, 3, 9, 10, 12, 11, 4, 7, 8, 9, 9};
  int v40[16] = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255};
  int v41a[16] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int v41b[16] = '{30, 29, 28, 27, 26, 25, 24, 23, 22, 21, 20, 19, 18, 17, 16, 2};
  int v42[16] = '{1, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
  int v43[16] = '{50, 50, 50, 40, 50, 50, 50, 50, 50, 50, 50, 50, 50, 50, 50, 50};

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_sad = 8'd0;
    repeat (2) @(posedge clk); #1;
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_sad",  sad0, 0);
    check("reset_tie",  tie0, 0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_sad = 8'd3;
    repeat (2) @(posedge clk); #1;
    in_valid = 1'b0;
    check("idle_no_start_busy", busy0, 0);
    check("idle_ignores_valid", sad0, 0);

    // Back-to-back search, both tie-break modes.
    pulse_start();
    check("scan_busy", busy0, 1);
    dn0_ref = dn0;
    feed(v38, 0, 14, 0);
    check("t38_no_early_done", done0, 0);
    feed(v38, 15, 15, 0);
    check("t38_done", done0, 1);
    check("t38_sad",  sad0, 3);
    check("t38_x",    x0, 1);
    check("t38_y",    y0, 0);
    check("t38_tie",  tie0, 2);
    check("t39_sad",  sad1, 3);
    check("t39_x",    x1, 1);
    check("t39_y",    y1, 2);
    check("t39_tie",  tie1, 2);
    @(posedge clk); #1;
    check("t38_done_one_cycle", done0, 0);
    check("t38_idle_busy", busy0, 0);
    check("t38_hold_sad", sad0, 3);
    check("t38_done_count", dn0 - dn0_ref, 1);

    // All-ones candidates with gaps between accepts.
    pulse_start();
    feed(v40, 0, 14, 1);
    check("t40_no_early_done", done0, 0);
    feed(v40, 15, 15, 0);
    check("t40_done", done0, 1);
    check("t40_sad",  sad0, 255);
    check("t40_x",    x0, 0);
    check("t40_y",    y0, 0);
    check("t40_tie",  tie0, 16);
    check("t40_last_x", x1, 3);
    check("t40_last_y", y1, 3);
    check("t40_last_tie", tie1, 16);

    // Start in the DONE cycle with a candidate present: that candidate is dropped.
    start = 1'b1; in_valid = 1'b1; in_sad = 8'd0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check("t43_restart_busy", busy0, 1);
    dn0_ref = dn0;
    feed(v43, 0, 14, 0);
    check("t43_no_early_done", done0, 0);
    feed(v43, 15, 15, 0);
    check("t43_done", done0, 1);
    check("t43_sad",  sad0, 40);
    check("t43_x",    x0, 0);
    check("t43_y",    y0, 3);
    @(posedge clk); #1;
    check("t43_done_count", dn0 - dn0_ref, 1);

    // Abort by a second Start mid-scan.
    dn0_ref = dn0;
    pulse_start();
    feed(v41a, 0, 4, 0);
    pulse_start();
    feed(v41b, 0, 15, 0);
    check("t41_done", done0, 1);
    check("t41_sad",  sad0, 2);
    check("t41_x",    x0, 3);
    check("t41_y",    y0, 3);
    check("t41_tie",  tie0, 1);
    @(posedge clk); #1;
    check("t41_done_count", dn0 - dn0_ref, 1);

    // Reset in the middle of a scan.
    pulse_start();
    feed(v38, 0, 7, 0);
    dn0_ref = dn0;
    rst_n = 1'b0;
    #1;
    check("t42_rst_busy", busy0, 0);
    check("t42_rst_sad",  sad0, 0);
    check("t42_rst_x",    x0, 0);
    check("t42_rst_y",    y0, 0);
    check("t42_rst_tie",  tie0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_sad = 8'd5;
    repeat (3) @(posedge clk); #1;
    in_valid = 1'b0;
    check("t42_no_done", dn0 - dn0_ref, 0);
    check("t42_no_autostart", busy0, 0);
    pulse_start();
    feed(v42, 0, 15, 0);
    check("t42_done", done0, 1);
    check("t42_sad",  sad0, 1);
    check("t42_x",    x0, 0);
    check("t42_y",    y0, 0);
    check("t42_tie",  tie0, 1);

    repeat (2) @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
